bitstream_sequencer: RTL and testbench
======================================

Name: bitstream_sequencer

Overview:
- Controller that drives the serial input of the team's Moore sequence-detector FSM.
- Detector interface: clock `Clock`, active-low synchronous reset `Resetn`, serial input `w`, output `z`.
- On `Start`, the block clears the detector, shifts out a latched pattern one bit per cycle, and counts cycles in which `z` is high.
- It then reports the count with a one-cycle `Done` pulse.
- It sits between the switch/key front end and the detector instance on the board top level.

Parameters:
- `WIDTH`, 16, maximum pattern length in bits.
- `CNT_W`, 5, width of the length and count fields. Must satisfy 2^CNT_W > WIDTH.

Ports:
- `Clock`  in  1  system clock, all logic on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  request to run one sequence. Sampled only in IDLE.
- `PatIn`  in  WIDTH  pattern word, latched on an accepted Start.
- `Len`  in  CNT_W  number of bits to send, latched on an accepted Start. 0 or >WIDTH is treated as WIDTH.
- `DetZ`  in  1  detector output z.
- `W`  out  1  serial bit to detector input w.
- `DetResetn`  out  1  drives detector Resetn (active low).
- `Busy`  out  1  high in CLR, SHIFT and DRAIN.
- `Done`  out  1  one-cycle pulse after a sequence completes.
- `MatchCount`  out  CNT_W  number of sampled cycles with DetZ=1.
- `State`  out  2  current state encoding, for LEDs.

Behaviour:
- Reset values (Reset=1 at an edge): State=IDLE, W=0, Busy=0, Done=0, MatchCount=0, internal shift register and bit counter=0.
- `DetResetn` = 0 combinationally whenever Reset=1 or State=CLR; otherwise 1.
- States:
  - IDLE=2'b00: W=0. Start=1 latches the pattern and length → CLR. Otherwise stay.
  - CLR=2'b01: one cycle. DetResetn=0, MatchCount cleared to 0, bit counter loaded with effective length L → SHIFT.
  - SHIFT=2'b10:
    - W = latched PatIn[L-1-k] on the k-th SHIFT cycle (k=0..L-1), i.e. the low L bits sent MSB-first.
    - Stay for exactly L cycles, then → DRAIN.
  - DRAIN=2'b11: one cycle, W=0 → IDLE. Done=1 in the first IDLE cycle.
- Sampling rule: the detector is Moore, so z for bit k appears in the cycle after bit k is driven.
  - DetZ is sampled on SHIFT cycles k=1..L-1 and on the DRAIN cycle: exactly L samples.
  - DetZ on SHIFT cycle k=0 is ignored.
- Each sample with DetZ=1 increments MatchCount. MatchCount saturates at 2^CNT_W-1 (no wrap).
- MatchCount holds its value in IDLE until the next CLR.
- Timing (Start high in cycle 0, IDLE):
  - CLR in cycle 1.
  - SHIFT in cycles 2..L+1.
  - DRAIN in cycle L+2.
  - Done=1 in cycle L+3.
  - Busy=1 in cycles 1..L+2.
- Start while Busy: ignored, not queued.
- Start in the Done cycle: accepted, because the block is in IDLE. Done still pulses exactly one cycle.
- Reset mid-operation: at the next edge go to IDLE. MatchCount=0, no Done pulse. The detector is held in reset for the same cycle(s).
- PatIn and Len changes after acceptance have no effect on the running sequence.

Optional Feature:
- Macro: `FIRST_MATCH_IDX_EN`.
- Defined:
  - Adds outputs `FirstIdx` [CNT_W-1:0] and `FirstValid` [0].
  - On the first DetZ=1 sample of a run, FirstIdx captures the index k of the bit that caused it (0-based, in send order) and FirstValid goes to 1.
  - Both clear in CLR and on Reset, and hold in IDLE.
- Undefined: the ports and logic are absent. All other behaviour is identical.

Test Plan:
- Reset=1 for 2 cycles, then release → all outputs 0, DetResetn=0 while Reset=1 and 1 after, State=00.
- PatIn=16'h000F, Len=4, pulse Start → W=1,1,1,1 in cycles 2..5, DetResetn=0 in cycle 1, Done in cycle 7, MatchCount=1 (FirstIdx=3).
- PatIn=16'h000D, Len=4 → detector path A→B→C→E→G, MatchCount=1 (FirstIdx=3).
- PatIn=16'h003F, Len=6 → MatchCount=3. Then PatIn=16'h0000, Len=0 (treated as 16) → Done in cycle 19, MatchCount=0, FirstValid=0.
- Start held high through a 4-bit run → no restart while Busy. A new run is accepted in the Done cycle (CLR the cycle after Done).
- Reset asserted in cycle 4 of a 6-bit run → IDLE at the next cycle, MatchCount=0, no Done pulse. A subsequent Start runs normally.

Source files
------------

// File: rtl/bitstream_sequencer.sv
// Drives the serial input of the Moore sequence detector with a latched pattern and counts the cycles where z is high.
// Optional FIRST_MATCH_IDX_EN adds FirstIdx/FirstValid to report the send index of the first match.
module bitstream_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] PatIn,
    input  logic [CNT_W-1:0] Len,
    input  logic             DetZ,
    output logic             W,
    output logic             DetResetn,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] MatchCount,
    output logic [1:0]       State
`ifdef FIRST_MATCH_IDX_EN
    ,
    output logic [CNT_W-1:0] FirstIdx,
    output logic             FirstValid
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLR   = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] WIDTH_C   = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

    // A zero or oversized length means "send the whole word".
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
        if ((len == ZERO_C) || (len > WIDTH_C)) begin
            eff_len = WIDTH_C;
        end else begin
            eff_len = len;
        end
    endfunction

    state_t             state_r;
    logic [WIDTH-1:0]   pat_r;
    logic [CNT_W-1:0]   len_r;
    logic [CNT_W-1:0]   bit_cnt_r;
    logic               w_r;
    logic               busy_r;
    logic               done_r;
    logic [CNT_W-1:0]   match_cnt_r;
    logic [WIDTH-1:0]   aligned_s;
    logic               sample_s;

    // Left-justify the active bits so the pattern leaves MSB-first from the top of the register.
    assign aligned_s = pat_r << (WIDTH_C - len_r);

    // z lags the driven bit by one cycle, so skip the first SHIFT cycle and include DRAIN.
    assign sample_s = ((state_r == ST_SHIFT) && (bit_cnt_r != len_r)) || (state_r == ST_DRAIN);

    // Detector reset follows the block reset so both start clean together.
    assign DetResetn  = ~(Reset | (state_r == ST_CLR));
    assign W          = w_r;
    assign Busy       = busy_r;
    assign Done       = done_r;
    assign MatchCount = match_cnt_r;
    assign State      = state_r;

    // Sequencer FSM with registered serial bit, status and match counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            pat_r       <= {WIDTH{1'b0}};
            len_r       <= ZERO_C;
            bit_cnt_r   <= ZERO_C;
            w_r         <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            match_cnt_r <= ZERO_C;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    w_r <= 1'b0;
                    if (Start) begin
                        pat_r   <= PatIn;
                        len_r   <= eff_len(Len);
                        busy_r  <= 1'b1;
                        state_r <= ST_CLR;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_CLR: begin
                    match_cnt_r <= ZERO_C;
                    bit_cnt_r   <= len_r;
                    w_r         <= aligned_s[WIDTH-1];
                    pat_r       <= aligned_s << 1;
                    state_r     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    bit_cnt_r <= bit_cnt_r - ONE_C;
                    if (bit_cnt_r == ONE_C) begin
                        w_r     <= 1'b0;
                        state_r <= ST_DRAIN;
                    end else begin
                        w_r     <= pat_r[WIDTH-1];
                        pat_r   <= pat_r << 1;
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DRAIN: begin
                    w_r     <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    w_r     <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
            if (sample_s && DetZ && (match_cnt_r != CNT_MAX_C)) begin
                match_cnt_r <= match_cnt_r + ONE_C;
            end
        end
    end

`ifdef FIRST_MATCH_IDX_EN
    logic [CNT_W-1:0] first_idx_r;
    logic             first_valid_r;
    logic [CNT_W-1:0] idx_s;

    // Bit counter is already one step ahead, which lines the index up with the bit that caused z.
    assign idx_s = len_r - bit_cnt_r - ONE_C;

    // Capture the send index of the first matching sample in each run.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            first_idx_r   <= ZERO_C;
            first_valid_r <= 1'b0;
        end else if (state_r == ST_CLR) begin
            first_idx_r   <= ZERO_C;
            first_valid_r <= 1'b0;
        end else if (sample_s && DetZ && !first_valid_r) begin
            first_idx_r   <= idx_s;
            first_valid_r <= 1'b1;
        end else begin
            first_idx_r   <= first_idx_r;
            first_valid_r <= first_valid_r;
        end
    end

    assign FirstIdx   = first_idx_r;
    assign FirstValid = first_valid_r;
`endif

endmodule

// File: tb/tb_bitstream_sequencer.sv
// Directed bench for bitstream_sequencer; a behavioural Moore detector for 1101/1111 (overlapping) drives DetZ.
module tb_bitstream_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [15:0] PatIn = 16'h0000;
    logic [4:0]  Len   = 5'd0;
    logic        DetZ;
    logic        W;
    logic        DetResetn;
    logic        Busy;
    logic        Done;
    logic [4:0]  MatchCount;
    logic [1:0]  State;
`ifdef FIRST_MATCH_IDX_EN
    logic [4:0]  FirstIdx;
    logic        FirstValid;
`endif

    int checks   = 0;
    int failures = 0;

    bitstream_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .PatIn      (PatIn),
        .Len        (Len),
        .DetZ       (DetZ),
        .W          (W),
        .DetResetn  (DetResetn),
        .Busy       (Busy),
        .Done       (Done),
        .MatchCount (MatchCount),
        .State      (State)
`ifdef FIRST_MATCH_IDX_EN
        ,
        .FirstIdx   (FirstIdx),
        .FirstValid (FirstValid)
`endif
    );

    always #5 Clock = ~Clock;

    // Detector model: state is the last four received bits, z decoded from state only.
    logic [3:0] hist;
    always @(posedge Clock) begin
        if (!DetResetn) hist <= 4'b0000;
        else            hist <= {hist[2:0], W};
    end
    assign DetZ = (hist == 4'b1101) || (hist == 4'b1111);

    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full run from an IDLE cycle; expected counts are supplied by the caller.
    task automatic run_seq(input logic [15:0] pat, input logic [4:0] len, input int eff,
                           input int exp_cnt, input int exp_idx, input logic exp_valid);
        Start = 1'b1; PatIn = pat; Len = len; #1;
        step();
        Start = 1'b0; PatIn = ~pat; Len = len + 5'd3; #1;
        check("clr_state", State, 32'd1);
        check("clr_detresetn", DetResetn, 32'd0);
        check("clr_busy", Busy, 32'd1);
        for (int k = 0; k < eff; k++) begin
            step();
            check("shift_state", State, 32'd2);
            check("shift_w", W, pat[eff-1-k]);
            check("shift_busy", Busy, 32'd1);
        end
        step();
        check("drain_state", State, 32'd3);
        check("drain_w", W, 32'd0);
        step();
        check("done_pulse", Done, 32'd1);
        check("done_state", State, 32'd0);
        check("done_busy", Busy, 32'd0);
        check("match_count", MatchCount, exp_cnt);
`ifdef FIRST_MATCH_IDX_EN
        check("first_idx", FirstIdx, exp_idx);
        check("first_valid", FirstValid, exp_valid);
`endif
        step();
        check("done_low", Done, 32'd0);
        check("count_hold", MatchCount, exp_cnt);
    endtask

    initial begin
        // Reset for two cycles, then release.
        step();
        check("rst_state", State, 32'd0);
        check("rst_w", W, 32'd0);
        check("rst_busy", Busy, 32'd0);
        check("rst_done", Done, 32'd0);
        check("rst_count", MatchCount, 32'd0);
        check("rst_detresetn", DetResetn, 32'd0);
        step();
        check("rst_detresetn2", DetResetn, 32'd0);
        Reset = 1'b0; #1;
        check("rel_detresetn", DetResetn, 32'd1);
        step();
        check("idle_state", State, 32'd0);

        run_seq(16'h000F, 5'd4, 4, 1, 3, 1'b1);
        run_seq(16'h000D, 5'd4, 4, 1, 3, 1'b1);
        run_seq(16'h003F, 5'd6, 6, 3, 3, 1'b1);
        run_seq(16'h0000, 5'd0, 16, 0, 0, 1'b0);
        run_seq(16'hFFFF, 5'd20, 16, 13, 3, 1'b1);
        run_seq(16'hA00D, 5'd4, 4, 1, 3, 1'b1);

        // Start held high: ignored while busy, re-accepted in the Done cycle.
        Start = 1'b1; PatIn = 16'h000F; Len = 5'd4; #1;
        step();
        check("hold_c1_clr", State, 32'd1);
        for (int c = 2; c <= 6; c++) begin
            step();
            check("hold_busy", Busy, 32'd1);
            check("hold_state", State, (c == 6) ? 32'd3 : 32'd2);
        end
        step();
        check("hold_c7_done", Done, 32'd1);
        check("hold_c7_idle", State, 32'd0);
        check("hold_c7_count", MatchCount, 32'd1);
        step();
        Start = 1'b0; #1;
        check("hold_c8_clr", State, 32'd1);
        check("hold_c8_done_low", Done, 32'd0);
        for (int c = 9; c <= 13; c++) step();
        check("hold_c13_drain", State, 32'd3);
        step();
        check("hold_c14_done", Done, 32'd1);
        check("hold_c14_count", MatchCount, 32'd1);
        step();

        // Reset in cycle 4 of a 6-bit run.
        Start = 1'b1; PatIn = 16'h003F; Len = 5'd6; #1;
        step();
        Start = 1'b0;
        step();
        step();
        step();
        Reset = 1'b1; #1;
        check("mid_rst_state", State, 32'd2);
        check("mid_rst_detresetn", DetResetn, 32'd0);
        step();
        Reset = 1'b0; #1;
        check("mid_rst_idle", State, 32'd0);
        check("mid_rst_count", MatchCount, 32'd0);
        check("mid_rst_busy", Busy, 32'd0);
        check("mid_rst_w", W, 32'd0);
        check("mid_rst_detresetn_rel", DetResetn, 32'd1);
        for (int c = 0; c < 3; c++) begin
            check("mid_rst_no_done", Done, 32'd0);
            step();
        end
        run_seq(16'h000D, 5'd4, 4, 1, 3, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
